// File: rtl/dmem_responder.sv
// Handshaked data-memory responder: one request at a time, byte-masked word store or word load,
// response returned LATENCY cycles after acceptance with read data and an error flag.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  // valid/ready: a transfer happens on a rising edge where both valid and ready are high;
  // a producer holds valid (and its payload) until that edge, and never withdraws it.

  localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH_LIM = 32'(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        lat_write;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_be;

  logic [31:0] mem [DEPTH_WORDS];

  logic             accept;
  logic             enter_resp;
  logic             acc_write;
  logic [31:0]      acc_addr;
  logic [31:0]      acc_wdata;
  logic [3:0]       acc_be;
  logic             acc_err;
  logic [IDX_W-1:0] acc_idx;
  logic             commit;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && req_ready;

  // With LATENCY=1 the access happens on the accept edge, before the latch holds the request.
  assign acc_write = (state == IDLE) ? req_write : lat_write;
  assign acc_addr  = (state == IDLE) ? req_addr  : lat_addr;
  assign acc_wdata = (state == IDLE) ? req_wdata : lat_wdata;
  assign acc_be    = (state == IDLE) ? req_be    : lat_be;

  assign enter_resp = ((state == IDLE) && accept && (LATENCY == 1)) ||
                      ((state == BUSY) && (cnt == 4'd1));
  assign acc_err    = (acc_addr[1:0] != 2'b00) || ({2'b00, acc_addr[31:2]} >= DEPTH_LIM);
  assign acc_idx    = acc_addr[IDX_W+1:2];
  assign commit     = enter_resp && !reset && acc_write && !acc_err;

  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_be[b]) mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      lat_write <= 1'b0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      lat_be    <= 4'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_be    <= req_be;
            if (LATENCY == 1) begin
              state <= RESP;
            end else begin
              state <= BUSY;
              cnt   <= 4'(LATENCY - 1);
            end
          end
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
      // Read returns the pre-write word; stores and errors answer with zero data.
      if (enter_resp) begin
        rsp_err   <= acc_err;
        rsp_rdata <= (acc_err || acc_write) ? 32'd0 : mem[acc_idx];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances (LATENCY 2, 1, 8) checked with immediate
// assertions against hand-computed values.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_write [3];
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic [3:0]  req_be    [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_err   [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_responder #(
      .DEPTH_WORDS(1024),
      .LATENCY((g == 0) ? 2 : ((g == 1) ? 1 : 8))
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_write(req_write[g]),
      .req_addr (req_addr[g]),
      .req_wdata(req_wdata[g]),
      .req_be   (req_be[g]),
      .rsp_valid(rsp_valid[g]),
      .rsp_ready(rsp_ready[g]),
      .rsp_rdata(rsp_rdata[g]),
      .rsp_err  (rsp_err[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction on unit u with rsp_ready held high; lat counts cycles from the accept
  // cycle to the first cycle showing rsp_valid.
  task automatic txn(input int u, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, output logic [31:0] rd, output logic er, output int lat);
    int n;
    @(negedge clk);
    req_valid[u] = 1'b1;
    req_write[u] = wr;
    req_addr[u]  = addr;
    req_wdata[u] = wdata;
    req_be[u]    = be;
    rsp_ready[u] = 1'b1;
    n = 0;
    while (!req_ready[u] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[u]) chk("accept_timeout", 32'(req_ready[u]), 32'd1);
    @(negedge clk);
    req_valid[u] = 1'b0;
    req_addr[u]  = $urandom;
    req_wdata[u] = $urandom;
    req_write[u] = 1'($urandom_range(0, 1));
    lat = 1;
    while (!rsp_valid[u] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid[u]) chk("rsp_timeout", 32'(rsp_valid[u]), 32'd1);
    rd = rsp_rdata[u];
    er = rsp_err[u];
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          n;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_valid[i] = 1'b0;
      req_write[i] = 1'b0;
      req_addr[i]  = 32'd0;
      req_wdata[i] = 32'd0;
      req_be[i]    = 4'd0;
      rsp_ready[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    chk("reset_req_ready", 32'(req_ready[0]), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata[0], 32'd0);
    chk("reset_rsp_err",   32'(rsp_err[0]),   32'd0);

    // store then load at 0x10
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
    chk("t1_store_lat",   32'(lat), 32'd2);
    chk("t1_store_err",   32'(er),  32'd0);
    chk("t1_store_rdata", rd,       32'd0);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    chk("t1_load_lat",   32'(lat), 32'd2);
    chk("t1_load_rdata", rd,       32'hDEADBEEF);
    chk("t1_load_err",   32'(er),  32'd0);

    // byte-masked merge and an all-zero byte-enable store
    txn(0, 1'b1, 32'h20, 32'h11223344, 4'hF, rd, er, lat);
    txn(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, er, lat);
    txn(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
    chk("t2_merge_rdata", rd, 32'h11BB33DD);
    txn(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, rd, er, lat);
    chk("t2_be0_err", 32'(er), 32'd0);
    txn(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
    chk("t2_be0_rdata", rd, 32'h11BB33DD);

    // misaligned load, out-of-range store, word 0 untouched
    txn(0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, rd, er, lat);
    txn(0, 1'b0, 32'h22, 32'h0, 4'h0, rd, er, lat);
    chk("t3_misalign_err",   32'(er), 32'd1);
    chk("t3_misalign_rdata", rd,      32'd0);
    txn(0, 1'b1, 32'h1000, 32'h12345678, 4'hF, rd, er, lat);
    chk("t3_range_err",   32'(er), 32'd1);
    chk("t3_range_rdata", rd,      32'd0);
    chk("t3_range_lat",   32'(lat), 32'd2);
    txn(0, 1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
    chk("t3_word0_rdata", rd, 32'hCAFEF00D);

    // response backpressure for 5 cycles
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_write[0] = 1'b0;
    req_addr[0]  = 32'h10;
    rsp_ready[0] = 1'b0;
    @(negedge clk);
    req_valid[0] = 1'b0;
    n = 0;
    while (!rsp_valid[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t4_rsp_lat", 32'(n + 1), 32'd2);
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", 32'(rsp_valid[0]), 32'd1);
      chk("t4_hold_rdata", rsp_rdata[0],      32'hDEADBEEF);
      chk("t4_hold_err",   32'(rsp_err[0]),   32'd0);
      chk("t4_hold_ready", 32'(req_ready[0]), 32'd0);
      @(negedge clk);
    end
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    chk("t4_after_ready", 32'(req_ready[0]), 32'd1);
    chk("t4_after_valid", 32'(rsp_valid[0]), 32'd0);
    chk("t4_after_rdata", rsp_rdata[0],      32'd0);

    // reset while a store is in BUSY
    txn(0, 1'b1, 32'hC, 32'h12345678, 4'hF, rd, er, lat);
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_write[0] = 1'b1;
    req_addr[0]  = 32'hC;
    req_wdata[0] = 32'h55;
    req_be[0]    = 4'hF;
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    req_valid[0] = 1'b0;
    chk("t5_busy_ready", 32'(req_ready[0]), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t5_post_valid", 32'(rsp_valid[0]), 32'd0);
    chk("t5_post_ready", 32'(req_ready[0]), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_no_rsp", 32'(rsp_valid[0]), 32'd0);
    end
    txn(0, 1'b0, 32'hC, 32'h0, 4'h0, rd, er, lat);
    chk("t5_old_value", rd, 32'h12345678);

    // LATENCY 1 and 8: single-transaction latency and back-to-back throughput
    for (int u = 1; u < 3; u++) begin
      int lexp;
      int acc_n;
      int last_acc;
      logic prev_v;
      lexp = (u == 1) ? 1 : 8;
      txn(u, 1'b1, 32'h40, 32'hA0000000 | u, 4'hF, rd, er, lat);
      chk("t6_store_lat", 32'(lat), 32'(lexp));
      txn(u, 1'b0, 32'h40, 32'h0, 4'h0, rd, er, lat);
      chk("t6_load_lat",   32'(lat), 32'(lexp));
      chk("t6_load_rdata", rd,       32'hA0000000 | u);
      @(negedge clk);
      req_valid[u] = 1'b1;
      req_write[u] = 1'b0;
      req_addr[u]  = 32'h40;
      rsp_ready[u] = 1'b1;
      acc_n    = 0;
      last_acc = -1;
      prev_v   = 1'b0;
      for (int i = 0; i < 4 * (lexp + 1); i++) begin
        if (req_valid[u] && req_ready[u]) begin
          chk("t6_no_overlap", 32'(rsp_valid[u]), 32'd0);
          if (last_acc >= 0) chk("t6_accept_gap", 32'(i - last_acc), 32'(lexp + 1));
          last_acc = i;
          acc_n++;
        end
        if (rsp_valid[u] && !prev_v) begin
          chk("t6_b2b_lat",   32'(i - last_acc), 32'(lexp));
          chk("t6_b2b_rdata", rsp_rdata[u],      32'hA0000000 | u);
        end
        prev_v = rsp_valid[u];
        @(negedge clk);
      end
      req_valid[u] = 1'b0;
      chk("t6_accept_count", 32'(acc_n), 32'd4);
      repeat (2) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
